// File: rtl/ram_copy_engine.sv
// ram_copy_engine: bus-master block copy / fill engine for one port of a
// dual-port RAM with a one-cycle registered read. Copies alternate a read
// cycle and a write cycle per word. Fills write one word per cycle.
module ram_copy_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_address,
  input  logic [ADDR_WIDTH-1:0] dst_address,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO    = '0;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH:0]   r_len;
  logic [DATA_WIDTH-1:0] r_fill;

  logic [ADDR_WIDTH:0]   w_len_sat;
  logic [ADDR_WIDTH:0]   w_idx_nxt;
  logic [ADDR_WIDTH-1:0] w_idx_nxt_lo;
  logic [ADDR_WIDTH-1:0] w_idx_lo;
  logic                  w_last;

  // Lengths beyond the RAM depth are clamped to one full pass of the RAM.
  assign w_len_sat    = (length > MAX_LEN) ? MAX_LEN : length;
  assign w_idx_nxt    = r_idx + ONE;
  assign w_idx_nxt_lo = w_idx_nxt[ADDR_WIDTH-1:0];
  assign w_idx_lo     = r_idx[ADDR_WIDTH-1:0];
  assign w_last       = (w_idx_nxt == r_len);

  assign busy             = r_busy;
  assign done             = r_done;
  assign ram_address      = r_addr;
  assign ram_write_enable = r_we;
  // Copy data flows straight from the RAM's registered output back into it.
  assign ram_write_data   = (r_state == S_WRITE) ? ram_read_data :
                            (r_state == S_FILL)  ? r_fill        : '0;

  // Latch the command on acceptance; these hold data only, so no reset.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && start) begin
      r_src  <= src_address;
      r_dst  <= dst_address;
      r_len  <= w_len_sat;
      r_fill <= fill_value;
    end
  end

  // Transfer FSM with registered address, strobe and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_we   <= 1'b0;
          r_addr <= '0;
          r_busy <= 1'b0;
          if (start) begin
            r_idx <= '0;
            if (w_len_sat == ZERO) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (!mode) begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
              r_addr  <= src_address;
            end else begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= dst_address;
            end
          end
        end
        S_READ: begin
          r_state <= S_WRITE;
          r_we    <= 1'b1;
          r_addr  <= r_dst + w_idx_lo;
        end
        S_WRITE: begin
          r_idx <= w_idx_nxt;
          r_we  <= 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_addr  <= '0;
          end else begin
            r_state <= S_READ;
            r_addr  <= r_src + w_idx_nxt_lo;
          end
        end
        S_FILL: begin
          r_idx <= w_idx_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_addr <= r_dst + w_idx_nxt_lo;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: a 4096x32 RAM model with registered read,
// a table of commands with hand-computed timing/address expectations,
// and directed sequences for reset abort and memory contents.
module tb_ram_copy_engine;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [11:0] src_address;
  logic [11:0] dst_address;
  logic [12:0] length;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic [11:0] ram_address;
  logic        ram_write_enable;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  ram_copy_engine #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .mode             (mode),
    .src_address      (src_address),
    .dst_address      (dst_address),
    .length           (length),
    .fill_value       (fill_value),
    .busy             (busy),
    .done             (done),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: write port shared between the engine and bench preload.
  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_address] <= ram_write_data;
    else if (pre_we)      mem[pre_addr]    <= pre_data;
    ram_read_data <= mem[ram_address];
  end

  typedef struct packed {
    logic        mode;
    logic [11:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    logic [31:0] fill;
    int          restart;
    int          exp_done;
    int          exp_wr;
    int          exp_busy;
    int          exp_rd;
    logic [11:0] wr0;
    logic [11:0] wrl;
    logic [11:0] rd0;
    logic [11:0] rdl;
  } vec_t;

  localparam int NVEC   = 7;
  localparam int BUDGET = 5000;

  vec_t        tbl [NVEC];
  int          checks;
  int          errors;
  logic [11:0] wr_log[$];
  logic [11:0] rd_log[$];
  int          nbusy;
  int          done_cyc;
  logic        idle_ok;
  logic        done_after;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  // Issue one command, then watch the engine cycle by cycle until done.
  task automatic run_cmd(input vec_t v);
    wr_log.delete();
    rd_log.delete();
    nbusy = 0; done_cyc = -1; idle_ok = 1'b0; done_after = 1'b1;
    @(posedge clock); #1;
    start = 1'b1; mode = v.mode; src_address = v.src; dst_address = v.dst;
    length = v.len; fill_value = v.fill;
    @(posedge clock); #1;
    // Command inputs are free to change once accepted.
    start = 1'b0; src_address = ~v.src; dst_address = ~v.dst;
    length = 13'h0005; fill_value = ~v.fill; mode = ~v.mode;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clock);
      if (busy) nbusy++;
      if (ram_write_enable) wr_log.push_back(ram_address);
      else if (busy) rd_log.push_back(ram_address);
      if (done) begin
        done_cyc = c;
        idle_ok  = (ram_address == 12'h000) && !ram_write_enable &&
                   (ram_write_data == 32'h0) && !busy;
        break;
      end
      if (v.restart != 0 && c == v.restart) begin
        start = 1'b1; mode = 1'b1; dst_address = 12'h300; length = 13'd5;
        fill_value = 32'hBAD0BAD0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clock);
    done_after = done;
  endtask

  task automatic check_run(input int i, input vec_t v);
    logic seq_ok;
    chk($sformatf("v%0d_done_cycle", i), done_cyc, v.exp_done);
    chk($sformatf("v%0d_writes", i), wr_log.size(), v.exp_wr);
    chk($sformatf("v%0d_reads", i), rd_log.size(), v.exp_rd);
    chk($sformatf("v%0d_busy_cycles", i), nbusy, v.exp_busy);
    chk($sformatf("v%0d_done_outs_zero", i), {31'b0, idle_ok}, 32'd1);
    chk($sformatf("v%0d_done_one_cycle", i), {31'b0, done_after}, 32'd0);
    if (v.exp_wr > 0 && wr_log.size() > 0) begin
      chk($sformatf("v%0d_first_wr", i), {20'b0, wr_log[0]}, {20'b0, v.wr0});
      chk($sformatf("v%0d_last_wr", i), {20'b0, wr_log[wr_log.size()-1]}, {20'b0, v.wrl});
    end
    if (v.exp_rd > 0 && rd_log.size() > 0) begin
      chk($sformatf("v%0d_first_rd", i), {20'b0, rd_log[0]}, {20'b0, v.rd0});
      chk($sformatf("v%0d_last_rd", i), {20'b0, rd_log[rd_log.size()-1]}, {20'b0, v.rdl});
    end
    seq_ok = 1'b1;
    for (int j = 1; j < rd_log.size(); j++)
      if (rd_log[j] != rd_log[j-1] + 12'd1) seq_ok = 1'b0;
    for (int j = 1; j < wr_log.size(); j++)
      if (wr_log[j] != wr_log[j-1] + 12'd1) seq_ok = 1'b0;
    chk($sformatf("v%0d_ascending", i), {31'b0, seq_ok}, 32'd1);
  endtask

  task automatic post_check(input int i);
    case (i)
      0: begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("fill_mem_%0h", 12'h010 + k), mem[12'h010 + k], 32'hDEADBEEF);
        chk("fill_below_untouched", mem[12'h00F], 32'h0F0F0F0F);
        chk("fill_above_untouched", mem[12'h014], 32'h14141414);
      end
      1: for (int k = 0; k < 8; k++)
           chk($sformatf("copy_mem_%0h", 12'h200 + k), mem[12'h200 + k], k);
      2: begin
        chk("wrap_mem_7fe", mem[12'h7FE], 32'h11);
        chk("wrap_mem_7ff", mem[12'h7FF], 32'h22);
        chk("wrap_mem_800", mem[12'h800], 32'h33);
        chk("wrap_mem_801", mem[12'h801], 32'h44);
      end
      3: for (int k = 0; k < 4; k++)
           chk($sformatf("overlap_mem_%0h", 12'h020 + k), mem[12'h020 + k], 32'hA0A0A0A0);
      4: chk("zero_len_dst_untouched", mem[12'h300], 32'hCAFE0300);
      5: begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("busy_copy_mem_%0h", 12'h280 + k), mem[12'h280 + k], k);
        chk("restart_fill_ignored", mem[12'h300], 32'hCAFE0300);
      end
      6: begin
        chk("sat_fill_mem_000", mem[12'h000], 32'h5A5A5A5A);
        chk("sat_fill_mem_fff", mem[12'hFFF], 32'h5A5A5A5A);
      end
      default: ;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks = 0; errors = 0;
    reset_n = 1'b1; start = 1'b0; mode = 1'b0; src_address = '0; dst_address = '0;
    length = '0; fill_value = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    //             mode  src     dst     len       fill          rs done  wr    busy  rd  wr0     wrl     rd0     rdl
    tbl[0] = '{1'b1, 12'h000, 12'h010, 13'd4,    32'hDEADBEEF, 0, 5,    4,    4,    0,  12'h010, 12'h013, 12'h000, 12'h000};
    tbl[1] = '{1'b0, 12'h100, 12'h200, 13'd8,    32'h00000000, 0, 17,   8,    16,   8,  12'h200, 12'h207, 12'h100, 12'h107};
    tbl[2] = '{1'b0, 12'hFFE, 12'h7FE, 13'd4,    32'h00000000, 0, 9,    4,    8,    4,  12'h7FE, 12'h801, 12'hFFE, 12'h001};
    tbl[3] = '{1'b0, 12'h020, 12'h021, 13'd3,    32'h00000000, 0, 7,    3,    6,    3,  12'h021, 12'h023, 12'h020, 12'h022};
    tbl[4] = '{1'b0, 12'h100, 12'h300, 13'd0,    32'h00000000, 0, 1,    0,    0,    0,  12'h000, 12'h000, 12'h000, 12'h000};
    tbl[5] = '{1'b0, 12'h100, 12'h280, 13'd8,    32'h00000000, 3, 17,   8,    16,   8,  12'h280, 12'h287, 12'h100, 12'h107};
    tbl[6] = '{1'b1, 12'h000, 12'h000, 13'h1FFF, 32'h5A5A5A5A, 0, 4097, 4096, 4096, 0,  12'h000, 12'hFFF, 12'h000, 12'h000};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_we", {31'b0, ram_write_enable}, 32'd0);
    chk("reset_addr", {20'b0, ram_address}, 32'd0);
    chk("reset_wdata", ram_write_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 8; k++) poke(12'h100 + k[11:0], k);
    poke(12'hFFE, 32'h11); poke(12'hFFF, 32'h22);
    poke(12'h000, 32'h33); poke(12'h001, 32'h44);
    poke(12'h020, 32'hA0A0A0A0); poke(12'h021, 32'hB0B0B0B0);
    poke(12'h022, 32'hC0C0C0C0); poke(12'h023, 32'hD0D0D0D0);
    poke(12'h00F, 32'h0F0F0F0F); poke(12'h014, 32'h14141414);
    poke(12'h300, 32'hCAFE0300);

    for (int i = 0; i < NVEC; i++) begin
      run_cmd(tbl[i]);
      check_run(i, tbl[i]);
      post_check(i);
    end

    // Reset during the third write of an 8-word fill.
    for (int k = 0; k < 8; k++) poke(12'h400 + k[11:0], 32'h0);
    @(posedge clock); #1;
    start = 1'b1; mode = 1'b1; dst_address = 12'h400; length = 13'd8;
    fill_value = 32'h12345678;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_pre_we", {31'b0, ram_write_enable}, 32'd1);
    chk("rst_mid_pre_addr", {20'b0, ram_address}, 32'h402);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_we", {31'b0, ram_write_enable}, 32'd0);
    chk("rst_mid_addr", {20'b0, ram_address}, 32'd0);
    chk("rst_mid_wdata", ram_write_data, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_after_busy", {31'b0, busy}, 32'd0);
    chk("rst_after_done", {31'b0, done}, 32'd0);
    chk("rst_word0", mem[12'h400], 32'h12345678);
    chk("rst_word1", mem[12'h401], 32'h12345678);
    chk("rst_word3", mem[12'h403], 32'h0);
    chk("rst_word7", mem[12'h407], 32'h0);

    v = '{1'b1, 12'h000, 12'h410, 13'd2, 32'h0BADF00D, 0, 3, 2, 2, 0,
          12'h410, 12'h411, 12'h000, 12'h000};
    run_cmd(v);
    check_run(7, v);
    chk("post_rst_mem_410", mem[12'h410], 32'h0BADF00D);
    chk("post_rst_mem_411", mem[12'h411], 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
